// File: rtl/regfile_multiport.sv
// Multiport register file: two registered read ports, one write port,
// self-clearing after reset, optional write-to-read bypass and zero register.
module regfile_multiport #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1,
  parameter int DEBUG_ADDR = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [ADDR_W-1:0] DBG  = ADDR_W'(DEBUG_ADDR);

  typedef enum logic {CLEAR, READY} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
  logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
  logic              rd_valid_q, rd_valid_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              usr_wr;

  function automatic logic [DATA_W-1:0] rd_val(
    input logic [ADDR_W-1:0] a,
    input logic              hit,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] cur
  );
    if (ZERO_REG && a == '0)
      return '0;
    else if (BYPASS && hit && wa == a)
      return wd;
    else
      return cur;
  endfunction

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    rd_data1_d = rd_data1_q;
    rd_data2_d = rd_data2_q;
    rd_valid_d = 1'b0;
    we         = 1'b0;
    waddr      = clr_cnt_q;
    wdata      = '0;
    usr_wr     = 1'b0;
    unique case (state_q)
      CLEAR: begin
        we        = 1'b1;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST)
          state_d = READY;
      end
      READY: begin
        // writes to a hardwired-zero entry are dropped, so never bypassed
        usr_wr = wr_en && !(ZERO_REG && wr_addr == '0);
        we     = usr_wr;
        waddr  = wr_addr;
        wdata  = wr_data;
        if (rd_en) begin
          rd_valid_d = 1'b1;
          rd_data1_d = rd_val(rd_addr1, usr_wr, wr_addr,
                              wr_data, mem_q[rd_addr1]);
          rd_data2_d = rd_val(rd_addr2, usr_wr, wr_addr,
                              wr_data, mem_q[rd_addr2]);
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= '0;
      rd_data1_q <= '0;
      rd_data2_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && we)
      mem_q[waddr] <= wdata;
  end

  assign rd_data1 = rd_data1_q;
  assign rd_data2 = rd_data2_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == CLEAR);
  assign dbg_data = mem_q[DBG];

endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register word width.
REQ-002 SHALL provide parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL provide parameter ZERO_REG, default 1, when 1 entry 0 is hardwired to zero.
REQ-004 SHALL provide parameter BYPASS, default 1, when 1 same-cycle write data is forwarded to reads.
REQ-005 SHALL provide parameter DEBUG_ADDR, default 3, entry exported on dbg_data.
REQ-006 SHALL have port clock  input  1  single clock, all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port rd_en  input  1  read request for both read ports.
REQ-009 SHALL have ports rd_addr1, rd_addr2  input  ADDR_W  read addresses.
REQ-010 SHALL have ports rd_data1, rd_data2  output  DATA_W  registered read data.
REQ-011 SHALL have port rd_valid  output  1  one-cycle pulse, rd_data1/2 hold fresh data.
REQ-012 SHALL have port wr_en  input  1  write request.
REQ-013 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-014 SHALL have port wr_data  input  DATA_W  write data.
REQ-015 SHALL have port busy  output  1  high while the clear sequence runs; requests ignored.
REQ-016 SHALL have port dbg_data  output  DATA_W  combinational view of entry DEBUG_ADDR.

Function
REQ-017 SHALL implement a two-state FSM: CLEAR, READY; busy = (state == CLEAR).
REQ-018 SHALL, in CLEAR, write 0 to entry clr_cnt each cycle and increment clr_cnt (ADDR_W bits).
REQ-019 SHALL transition CLEAR -> READY on the cycle that clears entry DEPTH-1; clear takes exactly DEPTH cycles after reset deasserts.
REQ-020 SHALL ignore rd_en and wr_en in CLEAR: no array write, rd_valid stays 0, rd_data1/2 hold.
REQ-021 SHALL, in READY with wr_en=1, write wr_data to entry wr_addr at the rising edge; visible to reads issued the next cycle.
REQ-022 SHALL, when ZERO_REG=1, discard writes to address 0 and return 0 for reads of address 0 regardless of bypass.
REQ-023 SHALL, in READY with rd_en=1, capture both ports at the rising edge: 1-cycle latency, rd_valid=1 on the following cycle only.
REQ-024 SHALL hold rd_data1/2 unchanged when no read is accepted; rd_valid=0 on those cycles.
REQ-025 SHALL, when BYPASS=1 and a read and a write to the same nonzero address are accepted in the same cycle, return wr_data; when BYPASS=0, return the pre-write value.
REQ-026 SHALL treat both read ports independently; rd_addr1 == rd_addr2 returns identical data on both.
REQ-027 SHALL update dbg_data from the array combinationally; a write to DEBUG_ADDR appears on dbg_data after that edge.
REQ-028 SHALL support back-to-back reads and writes every cycle with no stall in READY.

Reset
REQ-029 SHALL, at a rising edge with reset=1: state <= CLEAR, clr_cnt <= 0, rd_data1/2 <= 0, rd_valid <= 0.
REQ-030 SHALL hold clr_cnt at 0 while reset stays high; clearing progresses only after reset deasserts.
REQ-031 SHALL, on reset asserted mid-clear or mid-operation, abandon state and restart the clear at entry 0; pending read results are discarded (rd_valid 0).
REQ-032 SHALL not depend on initial blocks for array contents; post-clear all entries read 0.

Verification
REQ-033 Reset 1 cycle, then idle -> busy high exactly 32 cycles; after, reads of all 32 addresses return 0 with rd_valid one cycle after each rd_en.
REQ-034 After clear: write 0xDEADBEEF to addr 5, next cycle rd_addr1=5, rd_addr2=5 -> both rd_data = 0xDEADBEEF, rd_valid=1 one cycle later.
REQ-035 Same cycle wr_en addr 7 = 0x12345678 and rd_en rd_addr1=7 (prior 0) -> rd_data1 = 0x12345678 with BYPASS=1, 0x00000000 with BYPASS=0.
REQ-036 Write 0xFFFFFFFF to addr 0 (ZERO_REG=1), read addr 0 next cycle -> rd_data1 = 0; write 0x2A to addr 3 -> dbg_data = 0x2A the next cycle.
REQ-037 Assert reset at clear cycle 10, release -> busy high 32 further cycles; rd_en/wr_en during busy -> no rd_valid, array unchanged (all 0 after clear).
REQ-038 Parameter sweep ADDR_W=3, DATA_W=8 -> busy high 8 cycles; write/read of 0xA5 to addr 7 returns 0xA5.
